// File: rtl/fir_tdm_multichannel.sv
// Time-multiplexed multichannel FIR: one shared coefficient RAM, one delay line per channel,
// L MAC lanes per cycle. Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_tdm_multichannel #(
    parameter int N          = 211,
    parameter int L          = 2,
    parameter int CH         = 4,
    parameter int IN_WIDTH   = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 15,
    localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1,
    localparam int A_W       = $clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic [CH_W-1:0]             in_ch,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        coef_wr_en,
    input  logic [A_W-1:0]              coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_valid,
    output logic                        coef_err,
    output logic [1:0]                  state_dbg
);

    localparam int NUM_CYCLES = (N + L - 1) / L;
    localparam int CNT_W      = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam int P_W        = IN_WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] RND = (ACC_WIDTH'(1) << OUT_SHIFT) >> 1;

    // Handshake: a sample is taken on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, one sample is in flight at a time.
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    state_t                          state;
    logic signed [IN_WIDTH-1:0]      dline [CH][N];
    logic signed [COEF_WIDTH-1:0]    coef  [N];
    logic signed [ACC_WIDTH-1:0]     acc;
    logic [CNT_W-1:0]                cnt;
    logic [CH_W-1:0]                 cur_ch;

    logic signed [ACC_WIDTH-1:0]     lane_sum;
    logic signed [P_W-1:0]           prod;
    int                              idx;
    logic signed [ACC_WIDTH-1:0]     shifted;
    logic signed [OUT_WIDTH-1:0]     out_next;
    logic                            ch_ok;
    logic                            addr_ok;

    assign in_ready  = (state == IDLE);
    assign state_dbg = state;
    assign ch_ok     = ({1'b0, in_ch} < (CH_W + 1)'(CH));
    assign addr_ok   = ({1'b0, coef_addr} < (A_W + 1)'(N));

    // Taps cnt*L .. cnt*L+L-1 of the channel in flight; indices past the last tap contribute nothing.
    always_comb begin
        lane_sum = '0;
        prod     = '0;
        idx      = 0;
        for (int l = 0; l < L; l++) begin
            idx = int'(cnt) * L + l;
            if (idx < N) begin
                prod     = P_W'(dline[cur_ch][idx[A_W-1:0]]) * P_W'(coef[idx[A_W-1:0]]);
                lane_sum = lane_sum + ACC_WIDTH'(prod);
            end
        end
    end

    assign shifted = (acc + RND) >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = (ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX - ACC_WIDTH'(1);
    always_comb begin
        if (shifted > OUT_MAX)      out_next = OUT_WIDTH'(OUT_MAX);
        else if (shifted < OUT_MIN) out_next = OUT_WIDTH'(OUT_MIN);
        else                        out_next = OUT_WIDTH'(shifted);
    end
`else
    assign out_next = OUT_WIDTH'(shifted);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            cur_ch    <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
            for (int t = 0; t < N; t++) begin
                coef[t] <= '0;
                for (int c = 0; c < CH; c++) dline[c][t] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
            // Writes in IDLE land before an accept on the same edge is processed in ACC.
            if (coef_wr_en) begin
                if (state == IDLE && addr_ok) coef[coef_addr] <= coef_data;
                else                          coef_err        <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid && ch_ok) begin
                        for (int t = N - 1; t > 0; t--) dline[in_ch][t] <= dline[in_ch][t-1];
                        dline[in_ch][0] <= in_data;
                        acc    <= '0;
                        cnt    <= '0;
                        cur_ch <= in_ch;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + lane_sum;
                    if (cnt == CNT_W'(NUM_CYCLES - 1)) state <= DONE;
                    else                               cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    out_data  <= out_next;
                    out_ch    <= cur_ch;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_multichannel.sv
// Directed bench for fir_tdm_multichannel with N=5, L=2, CH=2, OUT_SHIFT=0.
// Build with FIR_SAT_EN defined to expect saturated overflow results.
module tb_fir_tdm_multichannel;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] in_data;
    logic [0:0]         in_ch;
    logic               in_valid;
    logic               in_ready;
    logic               coef_wr_en;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] out_data;
    logic [0:0]         out_ch;
    logic               out_valid;
    logic               coef_err;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    fir_tdm_multichannel #(
        .N(5), .L(2), .CH(2), .IN_WIDTH(16), .COEF_WIDTH(16),
        .ACC_WIDTH(40), .OUT_WIDTH(16), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid), .in_ready(in_ready),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .coef_err(coef_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
        @(negedge clk);
        coef_wr_en = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
    endtask

    // Drive one sample (optionally with a coefficient write on the same edge); returns 1 after the accept edge.
    task automatic send(input logic [0:0] ch, input logic signed [15:0] d,
                        input logic wr, input logic [2:0] wa, input logic signed [15:0] wd);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1; in_ch = ch; in_data = d;
        coef_wr_en = wr; coef_addr = wa; coef_data = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_wr_en = 1'b0;
    endtask

    // Wait for the result of the last accept; 'skip' edges after the accept are already consumed.
    task automatic wait_out(input string tag, input int skip,
                            input longint exp_d, input longint exp_ch);
        int  n    = skip;
        bit  seen = 1'b0;
        while (n < 12 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_ch"}, out_ch, exp_ch);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, out_valid, 0);
        check({tag, "_hold"}, out_data, exp_d);
    endtask

    typedef struct {
        logic [0:0]         ch;
        logic signed [15:0] d;
        longint             exp;
    } vec_t;

    vec_t imp_v [6] = '{
        '{1'b0, 16'sd100, 100}, '{1'b0, 16'sd0, 200}, '{1'b0, 16'sd0, 300},
        '{1'b0, 16'sd0, 400},   '{1'b0, 16'sd0, 500}, '{1'b0, 16'sd0, 0}
    };
    vec_t iso_v [10] = '{
        '{1'b0, 16'sd100, 100}, '{1'b1, -16'sd7, -7},
        '{1'b0, 16'sd0, 200},   '{1'b1, 16'sd0, -14},
        '{1'b0, 16'sd0, 300},   '{1'b1, 16'sd0, -21},
        '{1'b0, 16'sd0, 400},   '{1'b1, 16'sd0, -28},
        '{1'b0, 16'sd0, 500},   '{1'b1, 16'sd0, -35}
    };

    initial begin
        int pulses;
        rst = 1'b1; in_data = '0; in_ch = '0; in_valid = 1'b0;
        coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_coef_err", coef_err, 0);
        check("rst_state", state_dbg, 0);

        for (int i = 0; i < 5; i++) write_coef(3'(i), 16'(i + 1));

        for (int i = 0; i < 6; i++) begin
            send(imp_v[i].ch, imp_v[i].d, 1'b0, 3'd0, 16'sd0);
            wait_out($sformatf("impulse%0d", i), 0, imp_v[i].exp, imp_v[i].ch);
        end

        for (int i = 0; i < 10; i++) begin
            send(iso_v[i].ch, iso_v[i].d, 1'b0, 3'd0, 16'sd0);
            wait_out($sformatf("iso%0d", i), 0, iso_v[i].exp, iso_v[i].ch);
        end

        // Rejected write while busy: ch0 line becomes [100,0,0,0,0], coef0 stays 1.
        send(1'b0, 16'sd100, 1'b0, 3'd0, 16'sd0);
        coef_wr_en = 1'b1; coef_addr = 3'd0; coef_data = 16'sd50;
        check("busy_in_ready", in_ready, 0);
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
        check("coef_err_pulse", coef_err, 1);
        @(posedge clk); #1;
        check("coef_err_clear", coef_err, 0);
        wait_out("busy_wr", 2, 100, 0);
        send(1'b0, 16'sd0, 1'b0, 3'd0, 16'sd0);
        wait_out("busy_wr_next", 0, 200, 0);

        // Same-edge coef write and accept: ch1 [10,0,0,0,0] with coef0=3.
        send(1'b1, 16'sd10, 1'b1, 3'd0, 16'sd3);
        check("same_edge_no_err", coef_err, 0);
        wait_out("same_edge", 0, 30, 1);

        // Reset two edges after an accept discards the result.
        send(1'b0, 16'sd7, 1'b0, 3'd0, 16'sd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        @(negedge clk); rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_data", out_data, 0);
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("rst_no_pulse", pulses, 0);
        send(1'b1, 16'sd55, 1'b0, 3'd0, 16'sd0);
        wait_out("post_rst_zero", 0, 0, 1);

        // Overflow: 32767*32767 and -32767*32767 through coef0 only.
        write_coef(3'd0, 16'sd32767);
        send(1'b0, 16'sd32767, 1'b0, 3'd0, 16'sd0);
`ifdef FIR_SAT_EN
        wait_out("ovf_pos", 0, 32767, 0);
`else
        wait_out("ovf_pos", 0, 1, 0);
`endif
        send(1'b1, -16'sd32767, 1'b0, 3'd0, 16'sd0);
`ifdef FIR_SAT_EN
        wait_out("ovf_neg", 0, -32768, 1);
`else
        wait_out("ovf_neg", 0, -1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
